ifetch_unit: RTL
================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 Addr_Result  in  32  branch target as word address from the execute stage; bits [29:0] used.
REQ-005 Read_data_1  in  32  jr target byte address from the decoder.
REQ-006 Zero  in  1  ALU zero flag from the execute stage.
REQ-007 Branch, nBranch, Jmp, Jal, Jr  in  1 each  controller decodes for beq, bne, j, jal, jr.
REQ-008 imem_addr  out  32  instruction memory byte address, equal to PC.
REQ-009 imem_req  out  1  fetch request, level-held until acknowledged.
REQ-010 imem_rdata  in  32  instruction word, valid only while imem_ack=1.
REQ-011 imem_ack  in  1  memory completes the fetch this cycle.
REQ-012 advance  in  1  downstream consumed the current instruction; control inputs valid this cycle.
REQ-013 Instruction  out  32  registered fetched instruction.
REQ-014 PC_plus_4  out  32  combinational PC+4, mod 2^32.
REQ-015 link_addr  out  32  registered jal return address.
REQ-016 inst_valid  out  1  Instruction holds a valid, unconsumed word.

Function
REQ-017 PC SHALL be a 32-bit register; PC[1:0] SHALL always be 2'b00.
REQ-018 FSM states SHALL be REQ and VALID only.
REQ-019 In REQ: imem_req=1, inst_valid=0; when imem_ack=1, Instruction<=imem_rdata and the state SHALL move to VALID at the next edge.
REQ-020 Fetch latency SHALL be one cycle minimum: ack in cycle n -> inst_valid=1 in cycle n+1.
REQ-021 In VALID: imem_req=0, inst_valid=1; Instruction, PC and link_addr SHALL hold until advance=1.
REQ-022 On advance=1 in VALID: PC<=next_pc, and the state SHALL move to REQ at the next edge.
REQ-023 next_pc priority SHALL be: Jr -> {Read_data_1[31:2],2'b00}; else Jmp|Jal -> {PC_plus_4[31:28],Instruction[25:0],2'b00}; else (Branch&Zero)|(nBranch&~Zero) -> {Addr_Result[29:0],2'b00}; else PC_plus_4.
REQ-024 On advance=1 in VALID with Jal=1, link_addr SHALL be loaded with PC_plus_4; otherwise link_addr SHALL hold.
REQ-025 advance in REQ and imem_ack in VALID SHALL be ignored.
REQ-026 PC_plus_4 SHALL wrap: PC=0xFFFFFFFC gives 0x00000000.
REQ-027 Simultaneous Branch and nBranch SHALL resolve taken if either term is true. Jr together with Jal SHALL take the jr target and still load link_addr.

Reset
REQ-028 While reset=1: PC=0, state=REQ, Instruction=0, link_addr=0, inst_valid=0, imem_req=1, imem_addr=0, PC_plus_4=4.
REQ-029 Reset asserted mid-fetch SHALL discard any ack in flight; fetching SHALL restart at address 0 after release.

Verification
REQ-030 Release reset, imem_ack=1 in cycle 0 with rdata=0x20010005 -> imem_addr=0; cycle 1 inst_valid=1, Instruction=0x20010005; advance -> imem_addr=0x4.
REQ-031 PC=0x10, Branch=1, Zero=1, Addr_Result=0x20, advance -> imem_addr=0x80; same with Zero=0 -> 0x14.
REQ-032 PC=0x40, Instruction=0x0C000100, Jal=1, advance -> imem_addr=0x400, link_addr=0x44.
REQ-033 Jr=1, Jmp=1, Read_data_1=0x1237, advance -> imem_addr=0x1234 (jr priority, low bits cleared).
REQ-034 Hold imem_ack=0 for 5 cycles -> imem_req stays 1 and inst_valid stays 0. Then ack -> inst_valid=1 and holds with advance=0 for 3 cycles, with Instruction stable.
REQ-035 Assert reset in the REQ wait with PC=0x80 -> outputs return to REQ-028 values immediately; after release imem_addr=0.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: holds the PC, issues one fetch per instruction over a
// req/ack handshake and resolves the next PC from jump/branch decodes on advance.
module ifetch_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Addr_Result,
    input  logic [31:0] Read_data_1,
    input  logic        Zero,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jr,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        advance,
    output logic [31:0] Instruction,
    output logic [31:0] PC_plus_4,
    output logic [31:0] link_addr,
    output logic        inst_valid
);

    typedef enum logic [0:0] {
        ST_REQ   = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] link_q, link_d;
    logic [31:0] next_pc_s;
    logic        br_taken_s;

    // Next-PC selection; jr outranks j/jal, which outrank conditional branches
    always_comb begin
        next_pc_s  = PC_plus_4;
        br_taken_s = (Branch & Zero) | (nBranch & ~Zero);
        if (Jr) begin
            next_pc_s = {Read_data_1[31:2], 2'b00};
        end else if (Jmp | Jal) begin
            next_pc_s = {PC_plus_4[31:28], instr_q[25:0], 2'b00};
        end else if (br_taken_s) begin
            next_pc_s = {Addr_Result[29:0], 2'b00};
        end else begin
            next_pc_s = PC_plus_4;
        end
    end

    // Fetch handshake FSM and architectural register updates
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        link_d  = link_q;
        case (state_q)
            ST_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_VALID;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_VALID: begin
                if (advance) begin
                    pc_d    = next_pc_s;
                    state_d = ST_REQ;
                    // jr+jal still records the return address
                    if (Jal) begin
                        link_d = PC_plus_4;
                    end else begin
                        link_d = link_q;
                    end
                end else begin
                    state_d = ST_VALID;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_REQ;
            pc_q    <= 32'h0000_0000;
            instr_q <= 32'h0000_0000;
            link_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            link_q  <= link_d;
        end
    end

    assign PC_plus_4   = pc_q + 32'd4;
    assign imem_addr   = pc_q;
    assign imem_req    = (state_q == ST_REQ);
    assign inst_valid  = (state_q == ST_VALID);
    assign Instruction = instr_q;
    assign link_addr   = link_q;

endmodule
